// File: rtl/spi_slave.sv
// Mode-0 (CPOL=0, CPHA=0) MSB-first SPI target. SCK, CS and MOSI are oversampled
// on spi_clk, so SCK never clocks any logic directly.
module spi_slave #(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  spi_clk,
   input  logic                  reset,
   input  logic                  spi_scl,
   input  logic                  spi_cs,
   input  logic                  mosi,
   output logic                  miso,
   input  logic [DATA_WIDTH-1:0] tx_data,
   input  logic                  tx_load,
   output logic [DATA_WIDTH-1:0] rx_data,
   output logic                  rx_valid,
   output logic                  busy,
   output logic                  frame_err
);

   localparam int CW = $clog2(DATA_WIDTH + 1);

   typedef enum logic {IDLE, ACTIVE} state_t;

   state_t                state_q, state_d;
   logic [2:0]            scl_sync_q, scl_sync_d;
   logic [2:0]            cs_sync_q, cs_sync_d;
   logic [1:0]            mosi_sync_q, mosi_sync_d;
   logic [DATA_WIDTH-1:0] tx_buf_q, tx_buf_d;
   logic [DATA_WIDTH-1:0] tx_shift_q, tx_shift_d;
   logic [DATA_WIDTH-1:0] rx_shift_q, rx_shift_d;
   logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
   logic [CW-1:0]         bit_cnt_q, bit_cnt_d;
   logic                  rx_valid_q, rx_valid_d;
   logic                  busy_q, busy_d;
   logic                  frame_err_q, frame_err_d;

   logic sck_rise, sck_fall, cs_rise, cs_fall;

   // Stage [1] is the synchronised value; stage [2] is the previous one for edge detection.
   assign sck_rise = scl_sync_q[1] & ~scl_sync_q[2];
   assign sck_fall = ~scl_sync_q[1] & scl_sync_q[2];
   assign cs_rise  = cs_sync_q[1] & ~cs_sync_q[2];
   assign cs_fall  = ~cs_sync_q[1] & cs_sync_q[2];

   always_comb begin
      scl_sync_d  = {scl_sync_q[1:0], spi_scl};
      cs_sync_d   = {cs_sync_q[1:0], spi_cs};
      mosi_sync_d = {mosi_sync_q[0], mosi};
      tx_buf_d    = tx_load ? tx_data : tx_buf_q;
      state_d     = state_q;
      tx_shift_d  = tx_shift_q;
      rx_shift_d  = rx_shift_q;
      rx_data_d   = rx_data_q;
      bit_cnt_d   = bit_cnt_q;
      busy_d      = busy_q;
      rx_valid_d  = 1'b0;
      frame_err_d = 1'b0;

      // Reloads read tx_buf_d so a tx_load in the same cycle is picked up.
      case (state_q)
         IDLE: begin
            if (cs_fall) begin
               tx_shift_d = tx_buf_d;
               bit_cnt_d  = '0;
               busy_d     = 1'b1;
               state_d    = ACTIVE;
            end
         end
         ACTIVE: begin
            if (cs_rise) begin
               frame_err_d = (bit_cnt_q != '0);
               bit_cnt_d   = '0;
               busy_d      = 1'b0;
               state_d     = IDLE;
            end else if (bit_cnt_q == CW'(DATA_WIDTH)) begin
               rx_data_d  = rx_shift_q;
               rx_valid_d = 1'b1;
               bit_cnt_d  = '0;
               tx_shift_d = tx_buf_d;
            end else if (sck_rise) begin
               rx_shift_d = {rx_shift_q[DATA_WIDTH-2:0], mosi_sync_q[1]};
               bit_cnt_d  = bit_cnt_q + CW'(1);
            end else if (sck_fall && bit_cnt_q != '0) begin
               tx_shift_d = tx_shift_q << 1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge spi_clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         scl_sync_q  <= 3'b000;
         cs_sync_q   <= 3'b111;
         mosi_sync_q <= 2'b00;
         tx_buf_q    <= '0;
         tx_shift_q  <= '0;
         rx_shift_q  <= '0;
         rx_data_q   <= '0;
         bit_cnt_q   <= '0;
         rx_valid_q  <= 1'b0;
         busy_q      <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         scl_sync_q  <= scl_sync_d;
         cs_sync_q   <= cs_sync_d;
         mosi_sync_q <= mosi_sync_d;
         tx_buf_q    <= tx_buf_d;
         tx_shift_q  <= tx_shift_d;
         rx_shift_q  <= rx_shift_d;
         rx_data_q   <= rx_data_d;
         bit_cnt_q   <= bit_cnt_d;
         rx_valid_q  <= rx_valid_d;
         busy_q      <= busy_d;
         frame_err_q <= frame_err_d;
      end
   end

   assign miso      = (state_q == ACTIVE) & tx_shift_q[DATA_WIDTH-1];
   assign rx_data   = rx_data_q;
   assign rx_valid  = rx_valid_q;
   assign busy      = busy_q;
   assign frame_err = frame_err_q;

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: the bench acts as a mode-0 SPI master and checks
// received words, returned words, pulses and reset behaviour.
module tb_spi_slave;

   localparam int HALF = 8;

   logic       spi_clk = 1'b0;
   logic       reset;
   logic       spi_scl;
   logic       spi_cs;
   logic       mosi;
   logic       miso;
   logic [7:0] tx_data;
   logic       tx_load;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       busy;
   logic       frame_err;

   int         checks = 0;
   int         fails = 0;
   int         rv_cnt = 0;
   int         fe_cnt = 0;
   logic [7:0] rv_q[$];

   spi_slave #(.DATA_WIDTH(8)) dut (
      .spi_clk   (spi_clk),
      .reset     (reset),
      .spi_scl   (spi_scl),
      .spi_cs    (spi_cs),
      .mosi      (mosi),
      .miso      (miso),
      .tx_data   (tx_data),
      .tx_load   (tx_load),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .busy      (busy),
      .frame_err (frame_err)
   );

   always #5 spi_clk = ~spi_clk;

   // Counts high cycles of each pulse, so a stretched pulse shows up as an extra count.
   always @(negedge spi_clk) begin
      if (rx_valid) begin
         rv_cnt++;
         rv_q.push_back(rx_data);
      end
      if (frame_err) fe_cnt++;
   end

   task automatic wait_cycles(input int n);
      repeat (n) @(posedge spi_clk);
      #1;
   endtask

   task automatic start_frame();
      spi_cs = 1'b0;
      wait_cycles(HALF);
   endtask

   task automatic end_frame();
      spi_cs = 1'b1;
      wait_cycles(2 * HALF);
   endtask

   task automatic send_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
      rx = 8'h00;
      for (int i = 0; i < nbits; i++) begin
         mosi = tx[7-i];
         wait_cycles(HALF);
         rx = {rx[6:0], miso};
         spi_scl = 1'b1;
         wait_cycles(HALF);
         spi_scl = 1'b0;
      end
      wait_cycles(HALF);
   endtask

   task automatic load_tx(input logic [7:0] val);
      tx_data = val;
      tx_load = 1'b1;
      wait_cycles(1);
      tx_load = 1'b0;
   endtask

   task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic test_reset();
      reset = 1'b0;
      wait_cycles(4);
      check8("reset_miso", {7'd0, miso}, 8'h00);
      check8("reset_rx_data", rx_data, 8'h00);
      check8("reset_rx_valid", {7'd0, rx_valid}, 8'h00);
      check8("reset_busy", {7'd0, busy}, 8'h00);
      check8("reset_frame_err", {7'd0, frame_err}, 8'h00);
      reset = 1'b1;
      wait_cycles(4);
   endtask

   task automatic test_single_frame();
      logic [7:0] rx;
      int rv0;
      rv0 = rv_cnt;
      load_tx(8'h3c);
      wait_cycles(2);
      check8("idle_miso", {7'd0, miso}, 8'h00);
      start_frame();
      check8("single_busy_high", {7'd0, busy}, 8'h01);
      send_bits(8'h9a, 8, rx);
      end_frame();
      check8("single_master_rx", rx, 8'h3c);
      check8("single_rx_data", rx_data, 8'h9a);
      check8("single_rv_count", 8'(rv_cnt - rv0), 8'h01);
      if (rv_q.size() > 0) check8("single_rv_value", rv_q.pop_front(), 8'h9a);
      check8("single_busy_low", {7'd0, busy}, 8'h00);
      check8("single_no_err", 8'(fe_cnt), 8'h00);
   endtask

   task automatic test_back_to_back();
      logic [7:0] rx1, rx2;
      int rv0;
      rv_q.delete();
      rv0 = rv_cnt;
      load_tx(8'hc3);
      start_frame();
      send_bits(8'ha5, 8, rx1);
      send_bits(8'h0f, 8, rx2);
      end_frame();
      check8("b2b_rv_count", 8'(rv_cnt - rv0), 8'h02);
      if (rv_q.size() == 2) begin
         check8("b2b_word0", rv_q.pop_front(), 8'ha5);
         check8("b2b_word1", rv_q.pop_front(), 8'h0f);
      end
      check8("b2b_master_rx0", rx1, 8'hc3);
      check8("b2b_master_rx1", rx2, 8'hc3);
   endtask

   task automatic test_abort();
      logic [7:0] rx;
      int rv0, fe0;
      rv_q.delete();
      rv0 = rv_cnt;
      fe0 = fe_cnt;
      start_frame();
      send_bits(8'hf0, 5, rx);
      end_frame();
      check8("abort_err_count", 8'(fe_cnt - fe0), 8'h01);
      check8("abort_no_rv", 8'(rv_cnt - rv0), 8'h00);
      check8("abort_rx_kept", rx_data, 8'h0f);
      check8("abort_busy_low", {7'd0, busy}, 8'h00);
      start_frame();
      send_bits(8'h81, 8, rx);
      end_frame();
      check8("abort_next_rx", rx_data, 8'h81);
      check8("abort_next_master", rx, 8'hc3);
      check8("abort_next_err", 8'(fe_cnt - fe0), 8'h01);
   endtask

   task automatic test_preload();
      logic [7:0] rx1, rx2, rx;
      start_frame();
      send_bits(8'h00, 4, rx1);
      load_tx(8'hff);
      send_bits(8'h00, 4, rx2);
      end_frame();
      check8("preload_cur_master", {rx1[3:0], rx2[3:0]}, 8'hc3);
      check8("preload_cur_rx", rx_data, 8'h00);
      start_frame();
      send_bits(8'h12, 8, rx);
      end_frame();
      check8("preload_next_master", rx, 8'hff);
      check8("preload_next_rx", rx_data, 8'h12);
   endtask

   task automatic test_reset_mid_frame();
      logic [7:0] rx;
      int fe0;
      fe0 = fe_cnt;
      start_frame();
      send_bits(8'hff, 4, rx);
      #3;
      reset = 1'b0;
      #1;
      check8("midrst_rx_data", rx_data, 8'h00);
      check8("midrst_busy", {7'd0, busy}, 8'h00);
      check8("midrst_miso", {7'd0, miso}, 8'h00);
      check8("midrst_rx_valid", {7'd0, rx_valid}, 8'h00);
      spi_cs = 1'b1;
      wait_cycles(4);
      reset = 1'b1;
      wait_cycles(8);
      check8("midrst_no_err", 8'(fe_cnt - fe0), 8'h00);
      start_frame();
      send_bits(8'h55, 8, rx);
      end_frame();
      check8("midrst_after_rx", rx_data, 8'h55);
      check8("midrst_after_master", rx, 8'h00);
   endtask

   initial begin
      reset   = 1'b0;
      spi_scl = 1'b0;
      spi_cs  = 1'b1;
      mosi    = 1'b0;
      tx_data = 8'h00;
      tx_load = 1'b0;
      test_reset();
      test_single_frame();
      test_back_to_back();
      test_abort();
      test_preload();
      test_reset_mid_frame();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
